// File: rtl/core_multicycle.sv
// Multi-cycle RV32I core: one instruction at a time through FETCH/DECODE/EXEC/MEM/WB,
// with req/ready handshakes to external instruction and data memories.
module core_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        retire_o,
    output logic [31:0] pc_o,
    output logic        halt_o
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg, ir_reg, rs1_reg, rs2_reg, result_reg, next_pc_reg;
    logic [31:0] dmem_addr_reg, dmem_wdata_reg;
    logic        imem_req_reg, dmem_req_reg, dmem_we_reg, retire_reg, halt_reg;
    logic [31:0] regs [NUM_REGS];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    assign opcode = ir_reg[6:0];
    assign rd     = ir_reg[11:7];
    assign funct3 = ir_reg[14:12];
    assign funct7 = ir_reg[31:25];

    logic [31:0] imm, op_b, alu_out, exec_result, target, mem_addr;
    logic        illegal, uses_rd, uses_rs1, uses_rs2, taken, is_load, is_store, mis_target, mis_mem;

    always_comb begin
        case (opcode)
            OPC_LUI, OPC_AUIPC: imm = {ir_reg[31:12], 12'b0};
            OPC_JAL:    imm = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};
            OPC_BRANCH: imm = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
            OPC_STORE:  imm = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
            default:    imm = {{20{ir_reg[31]}}, ir_reg[31:20]};
        endcase
    end

    always_comb begin
        illegal  = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rd = 1'b1;
            OPC_JALR: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                illegal = (funct3 != 3'b010);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                illegal = (funct3 != 3'b010);
            end
            OPC_OPIMM: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1;
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'h00);
                else if (funct3 == 3'b101)
                    illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
            end
            OPC_OP: begin
                uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: illegal = 1'b1;
        endcase
        // RV32E: any referenced register above x15 is illegal
        if (NUM_REGS < 32)
            illegal = illegal || (uses_rd && rd[4]) || (uses_rs1 && ir_reg[19]) || (uses_rs2 && ir_reg[24]);
    end

    assign op_b = (opcode == OPC_OP) ? rs2_reg : imm;

    always_comb begin
        case (funct3)
            3'b000:  alu_out = ((opcode == OPC_OP) && funct7[5]) ? rs1_reg - op_b : rs1_reg + op_b;
            3'b001:  alu_out = rs1_reg << op_b[4:0];
            3'b010:  alu_out = {31'b0, $signed(rs1_reg) < $signed(op_b)};
            3'b011:  alu_out = {31'b0, rs1_reg < op_b};
            3'b100:  alu_out = rs1_reg ^ op_b;
            3'b101:  alu_out = funct7[5] ? 32'($signed(rs1_reg) >>> op_b[4:0]) : rs1_reg >> op_b[4:0];
            3'b110:  alu_out = rs1_reg | op_b;
            default: alu_out = rs1_reg & op_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = (rs1_reg == rs2_reg);
            3'b001:  taken = (rs1_reg != rs2_reg);
            3'b100:  taken = $signed(rs1_reg) < $signed(rs2_reg);
            3'b101:  taken = $signed(rs1_reg) >= $signed(rs2_reg);
            3'b110:  taken = rs1_reg < rs2_reg;
            default: taken = rs1_reg >= rs2_reg;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_LUI:           exec_result = imm;
            OPC_AUIPC:         exec_result = pc_reg + imm;
            OPC_JAL, OPC_JALR: exec_result = pc_reg + 32'd4;
            default:           exec_result = alu_out;
        endcase
        case (opcode)
            OPC_JAL:    target = pc_reg + imm;
            OPC_JALR:   target = (rs1_reg + imm) & ~32'd1;
            OPC_BRANCH: target = taken ? pc_reg + imm : pc_reg + 32'd4;
            default:    target = pc_reg + 32'd4;
        endcase
    end

    assign is_load    = (opcode == OPC_LOAD);
    assign is_store   = (opcode == OPC_STORE);
    assign mem_addr   = rs1_reg + imm;
    assign mis_mem    = (is_load || is_store) && (mem_addr[1:0] != 2'b00);
    assign mis_target = ((opcode == OPC_JAL) || (opcode == OPC_JALR) || ((opcode == OPC_BRANCH) && taken))
                        && (target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_FETCH;
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            result_reg     <= '0;
            next_pc_reg    <= '0;
            imem_req_reg   <= 1'b1;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            retire_reg     <= 1'b0;
            halt_reg       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            retire_reg <= 1'b0;
            case (state_reg)
                S_FETCH: if (imem_ready_i) begin
                    ir_reg       <= imem_rdata_i;
                    imem_req_reg <= 1'b0;
                    state_reg    <= S_DECODE;
                end
                S_DECODE: if (illegal) begin
                    halt_reg  <= 1'b1;
                    state_reg <= S_HALT;
                end else begin
                    rs1_reg   <= regs[ir_reg[15 +: RW]];
                    rs2_reg   <= regs[ir_reg[20 +: RW]];
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    next_pc_reg <= target;
                    if (mis_target || mis_mem) begin
                        halt_reg  <= 1'b1;
                        state_reg <= S_HALT;
                    end else if (is_load || is_store) begin
                        dmem_req_reg   <= 1'b1;
                        dmem_we_reg    <= is_store;
                        dmem_addr_reg  <= mem_addr;
                        dmem_wdata_reg <= is_store ? rs2_reg : '0;
                        state_reg      <= S_MEM;
                    end else begin
                        result_reg <= exec_result;
                        retire_reg <= 1'b1;
                        state_reg  <= S_WB;
                    end
                end
                S_MEM: if (dmem_ready_i) begin
                    dmem_req_reg   <= 1'b0;
                    dmem_we_reg    <= 1'b0;
                    dmem_addr_reg  <= '0;
                    dmem_wdata_reg <= '0;
                    // A store has nothing to write back, so its completing edge is its WB edge
                    if (dmem_we_reg) begin
                        pc_reg       <= next_pc_reg;
                        imem_req_reg <= 1'b1;
                        state_reg    <= S_FETCH;
                    end else begin
                        result_reg <= dmem_rdata_i;
                        retire_reg <= 1'b1;
                        state_reg  <= S_WB;
                    end
                end
                S_WB: begin
                    if (uses_rd && (rd != 5'd0))
                        regs[rd[RW-1:0]] <= result_reg;
                    pc_reg       <= next_pc_reg;
                    imem_req_reg <= 1'b1;
                    state_reg    <= S_FETCH;
                end
                S_HALT: ;
                default: begin
                    halt_reg  <= 1'b1;
                    state_reg <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req_o   = imem_req_reg;
    assign imem_addr_o  = pc_reg;
    assign dmem_req_o   = dmem_req_reg;
    assign dmem_we_o    = dmem_we_reg;
    assign dmem_addr_o  = dmem_addr_reg;
    assign dmem_wdata_o = dmem_wdata_reg;
    assign retire_o     = retire_reg || ((state_reg == S_MEM) && dmem_we_reg && dmem_ready_i);
    assign pc_o         = pc_reg;
    assign halt_o       = halt_reg;
endmodule

// File: tb/tb_core_multicycle.sv
// Scoreboard bench for core_multicycle: directed programs, wait-state memory models,
// expected retires/data accesses queued up front and checked by an independent monitor.
module tb_core_multicycle;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o, imem_ready_i, dmem_req_o, dmem_we_o, dmem_ready_i, retire_o, halt_o;
    logic [31:0] imem_addr_o, imem_rdata_i, dmem_addr_o, dmem_wdata_o, dmem_rdata_i, pc_o;

    core_multicycle #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
        .clock(clock), .reset(reset),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .retire_o(retire_o), .pc_o(pc_o), .halt_o(halt_o)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] OPI = 7'h13;

    logic [31:0] imem [256];
    logic [31:0] dm [64];
    int imem_wait = 0, dmem_wait = 0, iwait_cnt = 0, dwait_cnt = 0;
    int tests = 0, fails = 0, cyc = 0, last_ret_cyc = 0;
    logic [31:0] exp_ret_pc [$];
    int          exp_ret_gap [$];
    logic        exp_dm_we [$];
    logic [31:0] exp_dm_addr [$];
    logic [31:0] exp_dm_data [$];
    logic        prev_iw = 1'b0, prev_dw = 1'b0, prev_dwe = 1'b0;
    logic [31:0] prev_ia = '0, prev_da = '0, prev_dd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        imem[a[9:2]] = w;
    endtask
    task automatic fill();
        for (int i = 0; i < 256; i++) imem[i] = 32'hFFFF_FFFF;
    endtask
    task automatic push_ret(input logic [31:0] pc, input int gap);
        exp_ret_pc.push_back(pc);
        exp_ret_gap.push_back(gap);
    endtask
    task automatic push_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_dm_we.push_back(we);
        exp_dm_addr.push_back(a);
        exp_dm_data.push_back(d);
    endtask

    // Memory responders: ready after the configured number of wait cycles per request
    initial begin
        imem_ready_i = 1'b0; imem_rdata_i = '0; dmem_ready_i = 1'b0; dmem_rdata_i = '0;
        forever begin
            @(negedge clock);
            if (!reset && imem_req_o) begin
                if (iwait_cnt < imem_wait) begin imem_ready_i = 1'b0; iwait_cnt++; end
                else begin imem_ready_i = 1'b1; imem_rdata_i = imem[imem_addr_o[9:2]]; iwait_cnt = 0; end
            end else begin imem_ready_i = 1'b0; iwait_cnt = 0; end
            if (!reset && dmem_req_o) begin
                if (dwait_cnt < dmem_wait) begin dmem_ready_i = 1'b0; dwait_cnt++; end
                else begin
                    dmem_ready_i = 1'b1; dwait_cnt = 0;
                    if (dmem_we_o) dm[dmem_addr_o[7:2]] = dmem_wdata_o;
                    else dmem_rdata_i = dm[dmem_addr_o[7:2]];
                end
            end else begin dmem_ready_i = 1'b0; dwait_cnt = 0; end
        end
    end

    // Monitor: pops expectations whenever the core retires or completes a data access
    initial begin
        forever begin
            @(negedge clock); #1;
            cyc++;
            if (reset) begin
                prev_iw = 1'b0; prev_dw = 1'b0;
            end else begin
                if (retire_o) begin
                    if (exp_ret_pc.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_retire: got pc 0x%08h, expected no retire", pc_o);
                    end else begin
                        logic [31:0] epc;
                        int egap;
                        epc  = exp_ret_pc.pop_front();
                        egap = exp_ret_gap.pop_front();
                        chk("retire_pc", pc_o, epc);
                        if (egap != 0) chk("retire_gap", 32'(cyc - last_ret_cyc), 32'(egap));
                    end
                    last_ret_cyc = cyc;
                end
                if (dmem_req_o && dmem_ready_i) begin
                    if (exp_dm_we.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_dmem: got addr 0x%08h we %0d, expected no access", dmem_addr_o, dmem_we_o);
                    end else begin
                        logic ewe;
                        logic [31:0] ea, ed;
                        ewe = exp_dm_we.pop_front();
                        ea  = exp_dm_addr.pop_front();
                        ed  = exp_dm_data.pop_front();
                        chk("dmem_we", 32'(dmem_we_o), 32'(ewe));
                        chk("dmem_addr", dmem_addr_o, ea);
                        if (ewe) chk("dmem_wdata", dmem_wdata_o, ed);
                    end
                end
                if (imem_req_o && prev_iw) chk("imem_addr_hold", imem_addr_o, prev_ia);
                if (dmem_req_o && prev_dw) begin
                    chk("dmem_addr_hold", dmem_addr_o, prev_da);
                    chk("dmem_we_hold", 32'(dmem_we_o), 32'(prev_dwe));
                    chk("dmem_wdata_hold", dmem_wdata_o, prev_dd);
                end
                prev_iw = imem_req_o && !imem_ready_i; prev_ia = imem_addr_o;
                prev_dw = dmem_req_o && !dmem_ready_i; prev_da = dmem_addr_o;
                prev_dwe = dmem_we_o; prev_dd = dmem_wdata_o;
            end
        end
    end

    task automatic assert_reset();
        @(posedge clock); #2 reset = 1'b1;
        repeat (2) @(posedge clock);
    endtask
    task automatic release_reset();
        @(posedge clock); #2 reset = 1'b0;
        chk("rst_imem_req", 32'(imem_req_o), 32'd1);
        chk("rst_imem_addr", imem_addr_o, 32'h100);
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_retire", 32'(retire_o), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req_o), 32'd0);
        chk("rst_dmem_buses", dmem_addr_o | dmem_wdata_o | 32'(dmem_we_o), 32'd0);
    endtask

    task automatic wait_halt(input logic [31:0] hpc);
        int n = 0;
        while (!halt_o && n < 400) begin @(negedge clock); #1; n++; end
        chk("halt_o", 32'(halt_o), 32'd1);
        repeat (4) @(negedge clock);
        #1;
        chk("halt_pc", pc_o, hpc);
        chk("halt_no_req", 32'(imem_req_o) | 32'(dmem_req_o), 32'd0);
        chk("pending_retires", 32'(exp_ret_pc.size()), 32'd0);
        chk("pending_dmem", 32'(exp_dm_we.size()), 32'd0);
    endtask

    initial begin
        // Straight-line ALU, store, branch and jump program, zero-wait memories
        fill();
        put(32'h100, enc_i(12'd5, 0, 3'b000, 1, OPI));
        put(32'h104, enc_i(12'hFFD, 1, 3'b000, 2, OPI));
        put(32'h108, enc_s(12'h40, 2, 0));
        put(32'h10C, enc_i(12'd7, 0, 3'b000, 1, OPI));
        put(32'h110, enc_b(13'd8, 1, 1, 3'b000));
        put(32'h114, enc_i(12'd1, 0, 3'b000, 3, OPI));
        put(32'h118, enc_b(13'd8, 1, 1, 3'b001));
        put(32'h11C, enc_s(12'h44, 3, 0));
        put(32'h120, enc_i(12'd9, 0, 3'b000, 0, OPI));
        put(32'h124, enc_s(12'h48, 0, 0));
        put(32'h128, enc_i(12'h20, 0, 3'b000, 0, 7'h67));
        put(32'h020, enc_j(21'd16, 1));
        for (int a = 32'h24; a < 32'h30; a += 4) put(32'(a), enc_i(12'd1, 0, 3'b000, 1, OPI));
        put(32'h030, enc_s(12'h4C, 1, 0));
        put(32'h034, enc_i(12'hFFF, 0, 3'b000, 4, OPI));
        put(32'h038, enc_i(12'd28, 4, 3'b101, 5, OPI));
        put(32'h03C, enc_r(7'h20, 5, 0, 3'b000, 6));
        put(32'h040, enc_s(12'h50, 5, 0));
        put(32'h044, enc_s(12'h54, 6, 0));
        put(32'h048, {20'h12345, 5'd7, 7'h37});
        put(32'h04C, enc_s(12'h58, 7, 0));
        put(32'h050, enc_i(12'h404, 4, 3'b101, 8, OPI));
        put(32'h054, enc_r(7'h00, 4, 0, 3'b011, 9));
        put(32'h058, enc_r(7'h00, 0, 4, 3'b010, 10));
        put(32'h05C, enc_s(12'h5C, 8, 0));
        put(32'h060, enc_s(12'h60, 9, 0));
        put(32'h064, enc_s(12'h64, 10, 0));
        put(32'h068, 32'h0000_0073);
        push_ret(32'h100, 0);
        foreach (exp_ret_gap[i]) ;
        begin
            logic [31:0] pcs [24];
            pcs = '{32'h104, 32'h108, 32'h10C, 32'h110, 32'h118, 32'h11C, 32'h120, 32'h124,
                    32'h128, 32'h020, 32'h030, 32'h034, 32'h038, 32'h03C, 32'h040, 32'h044,
                    32'h048, 32'h04C, 32'h050, 32'h054, 32'h058, 32'h05C, 32'h060, 32'h064};
            for (int i = 0; i < 24; i++) push_ret(pcs[i], 4);
        end
        push_dm(1, 32'h40, 32'h2);        push_dm(1, 32'h44, 32'h0);
        push_dm(1, 32'h48, 32'h0);        push_dm(1, 32'h4C, 32'h24);
        push_dm(1, 32'h50, 32'hF);        push_dm(1, 32'h54, 32'hFFFF_FFF1);
        push_dm(1, 32'h58, 32'h1234_5000); push_dm(1, 32'h5C, 32'hFFFF_FFFF);
        push_dm(1, 32'h60, 32'h1);        push_dm(1, 32'h64, 32'h1);
        assert_reset();
        release_reset();
        wait_halt(32'h068);

        // Wait states: 3 on every fetch, 2 on every data access
        fill();
        imem_wait = 3; dmem_wait = 2;
        dm[4] = 32'hCAFE_BABE;
        put(32'h100, enc_i(12'h10, 0, 3'b000, 1, OPI));
        put(32'h104, enc_i(12'h0, 1, 3'b010, 5, 7'h03));
        put(32'h108, enc_s(12'd4, 5, 1));
        push_ret(32'h100, 0); push_ret(32'h104, 10); push_ret(32'h108, 9);
        push_dm(0, 32'h10, 32'h0); push_dm(1, 32'h14, 32'hCAFE_BABE);
        assert_reset();
        release_reset();
        wait_halt(32'h10C);
        imem_wait = 0; dmem_wait = 0;

        // ECALL halts without retiring
        fill();
        put(32'h100, 32'h0000_0073);
        assert_reset();
        release_reset();
        wait_halt(32'h100);

        // Misaligned LW halts before any data request
        fill();
        put(32'h100, enc_i(12'h42, 0, 3'b010, 1, 7'h03));
        assert_reset();
        release_reset();
        wait_halt(32'h100);

        // Taken branch to a misaligned target halts
        fill();
        put(32'h100, enc_b(13'd6, 0, 0, 3'b000));
        assert_reset();
        release_reset();
        wait_halt(32'h100);

        // Reset while a load is stalled in MEM, then a clean restart
        fill();
        put(32'h100, enc_i(12'd3, 0, 3'b000, 2, OPI));
        put(32'h104, enc_i(12'h10, 0, 3'b010, 1, 7'h03));
        put(32'h108, enc_s(12'h18, 1, 0));
        dmem_wait = 50;
        push_ret(32'h100, 0);
        assert_reset();
        release_reset();
        begin
            int n = 0;
            while (!dmem_req_o && n < 100) begin @(negedge clock); #1; n++; end
        end
        chk("mem_stall_req", 32'(dmem_req_o), 32'd1);
        repeat (2) @(negedge clock);
        @(posedge clock); #2 reset = 1'b1;
        @(posedge clock); #2;
        chk("abort_dmem_req", 32'(dmem_req_o), 32'd0);
        chk("abort_pc", pc_o, 32'h100);
        dmem_wait = 0;
        dm[4] = 32'h0BAD_F00D;
        push_ret(32'h100, 0); push_ret(32'h104, 5); push_ret(32'h108, 4);
        push_dm(0, 32'h10, 32'h0); push_dm(1, 32'h18, 32'h0BAD_F00D);
        release_reset();
        wait_halt(32'h10C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end
endmodule
